// File: rtl/seg7_rx_decoder.sv
// Receive-side 7-segment bus decoder: synchronise, glitch-filter, decode to hex, check roulette order.
// Optional stop detection is enabled with `define SEG7_RX_STOP_DETECT_EN.
module seg7_rx_decoder #(
    parameter int unsigned DIV_BITS   = 15,
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned STOP_BITS  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in_n,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       blank,
    output logic       invalid,
    output logic       dp,
    output logic       new_pulse,
    output logic [7:0] seq_err_cnt,
    output logic       stopped
);

    localparam int unsigned STAB_W = 4;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    if (STABLE_CNT < 1 || STABLE_CNT > 15 || STOP_BITS < 1) begin : g_bad_params
        $error("seg7_rx_decoder: STABLE_CNT must be 1..15 and STOP_BITS at least 1");
    end

    logic [7:0]          sync1, sync2;
    logic [DIV_BITS-1:0] div;
    logic                tick;
    logic [7:0]          cand, cand_nx, acc, glyph;
    logic [STAB_W-1:0]   stab, stab_nx;
    logic                accept;
    logic [3:0]          dec_digit;
    logic                dec_valid, dec_blank, dec_invalid;
    logic [0:0]          state, state_nx;
    logic [3:0]          prev, prev_nx, succ;
    logic                err_inc;

    // Two-flop synchroniser; idle bus (all segments off) is the reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
        end else begin
            sync1 <= seg_in_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else        div <= div + DIV_BITS'(1);
    end

    assign tick = &div;

    // Stability filter; a new pattern is accepted when its run reaches STABLE_CNT ticks
    always_comb begin
        cand_nx = cand;
        stab_nx = stab;
        if (tick) begin
            if (sync2 != cand) begin
                cand_nx = sync2;
                stab_nx = STAB_W'(1);
            end else if (stab < STAB_W'(STABLE_CNT)) begin
                stab_nx = stab + STAB_W'(1);
            end
        end
    end

    assign accept = tick && (stab_nx == STAB_W'(STABLE_CNT)) && (cand_nx != acc);

    // Glyph match ignores the dp bit by forcing it to the off level
    assign glyph = {cand_nx[7:1], 1'b1};

    always_comb begin
        dec_digit   = 4'd0;
        dec_valid   = 1'b1;
        dec_blank   = 1'b0;
        dec_invalid = 1'b0;
        case (glyph)
            8'h03: dec_digit = 4'h0;
            8'h9F: dec_digit = 4'h1;
            8'h25: dec_digit = 4'h2;
            8'h0D: dec_digit = 4'h3;
            8'h99: dec_digit = 4'h4;
            8'h49: dec_digit = 4'h5;
            8'h41: dec_digit = 4'h6;
            8'h1F: dec_digit = 4'h7;
            8'h01: dec_digit = 4'h8;
            8'h09: dec_digit = 4'h9;
            8'h11: dec_digit = 4'hA;
            8'hC1: dec_digit = 4'hB;
            8'hE5: dec_digit = 4'hC;
            8'h85: dec_digit = 4'hD;
            8'h61: dec_digit = 4'hE;
            8'h71: dec_digit = 4'hF;
            8'hFF: begin
                dec_valid = 1'b0;
                dec_blank = 1'b1;
            end
            default: begin
                dec_valid   = 1'b0;
                dec_invalid = 1'b1;
            end
        endcase
    end

    // Decoded outputs are captured together with acc so they always reflect it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand        <= 8'hFF;
            acc         <= 8'hFF;
            stab        <= '0;
            new_pulse   <= 1'b0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            blank       <= 1'b1;
            invalid     <= 1'b0;
            dp          <= 1'b0;
        end else begin
            cand      <= cand_nx;
            stab      <= stab_nx;
            new_pulse <= accept;
            if (accept) begin
                acc         <= cand_nx;
                digit       <= dec_digit;
                digit_valid <= dec_valid;
                blank       <= dec_blank;
                invalid     <= dec_invalid;
                dp          <= ~cand_nx[0];
            end
        end
    end

    assign succ = (prev == 4'd9) ? 4'd0 : prev + 4'd1;

    // Sequence checker, advanced only in the new_pulse cycle
    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        err_inc  = 1'b0;
        if (new_pulse) begin
            if (blank) begin
                state_nx = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (digit_valid && digit <= 4'd9) begin
                            state_nx = TRACK;
                            prev_nx  = digit;
                        end
                    end
                    default: begin
                        if (digit_valid && digit <= 4'd9) begin
                            err_inc = (digit != succ);
                            prev_nx = digit;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev        <= 4'd0;
            seq_err_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            prev  <= prev_nx;
            if (err_inc && seq_err_cnt != 8'hFF) seq_err_cnt <= seq_err_cnt + 8'd1;
        end
    end

`ifdef SEG7_RX_STOP_DETECT_EN
    logic [STOP_BITS-1:0] stop_cnt, stop_cnt_nx;

    // Counts ticks of an unchanged tracked digit; cleared already at acceptance
    always_comb begin
        stop_cnt_nx = stop_cnt;
        if (state == IDLE || accept || new_pulse) stop_cnt_nx = '0;
        else if (tick && !(&stop_cnt))            stop_cnt_nx = stop_cnt + STOP_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_cnt <= '0;
            stopped  <= 1'b0;
        end else begin
            stop_cnt <= stop_cnt_nx;
            stopped  <= &stop_cnt_nx;
        end
    end
`else
    assign stopped = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Scoreboard bench for seg7_rx_decoder with a fast prescaler (one tick every 4 clk).
module tb_seg7_rx_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seg_in_n = 8'hFF;
    logic [3:0] digit;
    logic       digit_valid, blank, invalid, dp, new_pulse, stopped;
    logic [7:0] seq_err_cnt;

    typedef struct packed {
        logic [3:0] digit;
        logic       valid;
        logic       blank;
        logic       invalid;
        logic       dp;
        logic [7:0] err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    seg7_rx_decoder #(.DIV_BITS(2), .STABLE_CNT(3), .STOP_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in_n(seg_in_n),
        .digit(digit), .digit_valid(digit_valid), .blank(blank), .invalid(invalid),
        .dp(dp), .new_pulse(new_pulse), .seq_err_cnt(seq_err_cnt), .stopped(stopped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic ev(input logic [3:0] d, input logic v, input logic b, input logic inv,
                      input logic p, input logic [7:0] e);
        q.push_back({d, v, b, inv, p, e});
    endtask

    // Inputs change 1 time unit after a rising edge and are held for cyc clocks
    task automatic drive(input logic [7:0] p, input int cyc);
        seg_in_n = p;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_digit", digit, 4'd0);
        chk("rst_digit_valid", digit_valid, 1'b0);
        chk("rst_blank", blank, 1'b1);
        chk("rst_invalid", invalid, 1'b0);
        chk("rst_dp", dp, 1'b0);
        chk("rst_new_pulse", new_pulse, 1'b0);
        chk("rst_seq_err_cnt", seq_err_cnt, 8'd0);
        chk("rst_stopped", stopped, 1'b0);
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        check_reset();
        seg_in_n = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every new_pulse pops one expectation; the error count settles one clk later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && new_pulse) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=digit %0h blank %0b invalid %0b required=no pulse",
                             digit, blank, invalid);
                end else begin
                    e = q.pop_front();
                    chk("ev_digit", digit, e.digit);
                    chk("ev_digit_valid", digit_valid, e.valid);
                    chk("ev_blank", blank, e.blank);
                    chk("ev_invalid", invalid, e.invalid);
                    chk("ev_dp", dp, e.dp);
                    @(negedge clk);
                    chk("ev_seq_err_cnt", seq_err_cnt, e.err);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq_pat [11];
        logic [3:0] seq_dig [11];
        logic [7:0] alt_pat;
        logic [3:0] alt_dig;
        int         hit;
        seq_pat = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09, 8'h03};
        seq_dig = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};

        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        // Idle bus: nothing may be accepted
        drive(8'hFF, 60);
        chk("idle_blank", blank, 1'b1);
        chk("idle_seq_err_cnt", seq_err_cnt, 8'd0);

        // Digit 0, then the same glyph with dp lit
        ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'h03, 32);
        ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        drive(8'h02, 32);

        // Short 0x9F glitch inside a 0x03 run is rejected
        ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        drive(8'h03, 8);
        drive(8'h9F, 4);
        drive(8'h03, 32);
        drain();
        chk("glitch_digit", digit, 4'd0);
        chk("glitch_dp", dp, 1'b0);

        // Clean roulette order 0..9,0 from a fresh reset
        reset_mid();
        for (int i = 0; i < 11; i++) begin
            ev(seq_dig[i], 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
            drive(seq_pat[i], 16);
        end
        ev(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        drive(8'h99, 16);
        ev(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        drive(8'h55, 16);
        drain();
        chk("invalid_flag", invalid, 1'b1);

        // Alternating 2 and 4 is always out of order: counter saturates
        for (int k = 1; k <= 300; k++) begin
            alt_pat = (k % 2 == 1) ? 8'h25 : 8'h99;
            alt_dig = (k % 2 == 1) ? 4'd2 : 4'd4;
            ev(alt_dig, 1'b1, 1'b0, 1'b0, 1'b0, (2 + k > 255) ? 8'd255 : 8'(2 + k));
            drive(alt_pat, 16);
        end
        ev(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255);
        drive(8'hFF, 16);
        ev(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
        drive(8'h49, 16);
        drain();
        chk("saturated_cnt", seq_err_cnt, 8'd255);

        // Blank returns to IDLE: hex A there and a restart at 5 are not errors
        reset_mid();
        ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'h03, 16);
        ev(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'h9F, 16);
        ev(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(8'hFF, 16);
        ev(4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'h11, 16);
        ev(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'h49, 16);
        ev(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        drive(8'h1F, 16);
`ifdef SEG7_RX_STOP_DETECT_EN
        hit = 0;
        for (int i = 0; i < 100 && hit == 0; i++) begin
            @(negedge clk);
            if (stopped) hit = 1;
        end
        chk("stopped_set", hit, 1);
        ev(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        @(posedge clk);
        #1;
        seg_in_n = 8'h01;
        hit = 0;
        for (int i = 0; i < 60 && hit == 0; i++) begin
            @(negedge clk);
            if (new_pulse) hit = 1;
        end
        chk("pulse_after_stop", hit, 1);
        chk("stopped_clear_on_pulse", stopped, 1'b0);
        hit = 0;
        for (int i = 0; i < 100 && hit == 0; i++) begin
            @(negedge clk);
            if (stopped) hit = 1;
        end
        chk("stopped_set_again", hit, 1);
        @(posedge clk);
        #1;
        drain();
`else
        drive(8'h1F, 60);
        chk("stopped_tied_low", stopped, 1'b0);
        ev(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        drive(8'h01, 16);
        drain();
`endif
        chk("track_digit", digit, 4'd8);
        chk("track_seq_err_cnt", seq_err_cnt, 8'd1);

        // Reset while holding a tracked digit
        seg_in_n = 8'h01;
        reset_mid();
        drive(8'hFF, 40);
        chk("post_reset_blank", blank, 1'b1);
        chk("final_queue", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
